traffic_request_arbiter: RTL and testbench
==========================================

// Module: traffic_request_arbiter
// PURPOSE
//  Captures the three push-button service requests (NS walk, EW walk, southbound left turn),
//  holds them as pending, and grants one at a time to the traffic controller FSM by round-robin.
//  Sits between the board KEY inputs and traffic_controller; the controller asks for a request
//  only at phase boundaries and reports when that service is finished.
// PARAMETERS
//  SYNC_STAGES  2    flops in each button synchronizer (>=2)
//  ACK_TIMEOUT  255  clk_27 cycles in OFFER without grant_ack before the grant is withdrawn
//  TO_W         8    width of timeout counter; must hold ACK_TIMEOUT
// PORTS
//  clk_27                       in   1  system clock; all logic on its rising edge
//  reset                        in   1  asynchronous, active-high reset
//  not_ns_walk_request          in   1  NS walk button, active-low, asynchronous
//  not_ew_walk_request          in   1  EW walk button, active-low, asynchronous
//  not_southbound_left_request  in   1  left-turn button, active-low, asynchronous
//  slot_ready                   in   1  controller at phase boundary, can accept a service
//  grant_ack                    in   1  controller accepts the offered grant (1-cycle pulse)
//  service_done                 in   1  controller finished the granted service (1-cycle pulse)
//  grant                        out  3  one-hot {left, ew_walk, ns_walk}; valid when grant_valid
//  grant_valid                  out  1  grant offered / being serviced
//  pending                      out  3  latched requests {left, ew_walk, ns_walk}
//  walk_request_waiting         out  1  |pending
//  timeout_err                  out  1  1-cycle pulse when an offer times out
// BEHAVIOUR
//  Reset (async): sync flops -> 1 (idle button, no false edge); pending=0, grant=0,
//   grant_valid=0, timeout_err=0, rr_ptr=0 (ns_walk), state=IDLE, counter=0.
//  Capture: each button through SYNC_STAGES flops, then falling-edge detect (prev=1, cur=0).
//   Edge sets pending[i]. Pending visible SYNC_STAGES+1 cycles after first low sample.
//   Held-low button sets once only; edge on an already-pending bit is absorbed.
//  Priority: search pending starting at rr_ptr, ascending mod 3; first set bit wins.
//  FSM:
//   IDLE : if slot_ready && |pending -> latch winner into grant, grant_valid=1 next cycle, go OFFER.
//          slot_ready with pending==0 -> stay IDLE.
//   OFFER: grant held stable. grant_ack -> clear pending[winner], go BUSY, counter=0.
//          no ack: counter++; when counter==ACK_TIMEOUT-1 and no ack -> grant_valid=0, grant=0,
//          pending kept, rr_ptr=winner+1 mod 3, timeout_err pulse 1 cycle, go IDLE.
//          ack on the timeout cycle wins (go BUSY, no error).
//   BUSY : grant_valid stays 1. service_done -> grant=0, grant_valid=0,
//          rr_ptr=winner+1 mod 3, go IDLE (next grant earliest 1 cycle later).
//  Simultaneous/boundary:
//   - edge on winner bit in same cycle as grant_ack: pending[winner] stays 1 (new request kept).
//   - edge on winner bit during BUSY: sets pending again; served in a later slot.
//   - slot_ready in OFFER/BUSY ignored; grant_ack outside OFFER ignored;
//     service_done outside BUSY ignored.
//   - all three pending: served in rr order, so each waits at most two other services.
//   - reset mid-OFFER/BUSY: grant and grant_valid drop immediately, all pending lost.
//  walk_request_waiting, pending combinational from pending regs (no extra latency).
// TESTING
//  1 Reset: hold reset, toggle buttons -> all outputs 0; release, no edges -> pending stays 0.
//  2 Press ns_walk (low 10 cycles) -> pending=3'b001 at cycle SYNC_STAGES+1; slot_ready ->
//    next cycle grant=001, grant_valid=1; ack -> pending=000; service_done -> grant_valid=0.
//  3 Press all three, then repeat slot_ready/ack/done x3 -> grants 001,010,100; rr_ptr back to 0.
//  4 Grant 010 offered, no ack for ACK_TIMEOUT cycles -> grant_valid=0, timeout_err 1-cycle pulse,
//    pending=010; next slot_ready with 001 also pending -> grant=001? no: rr_ptr=2 -> grant=100
//    if set, else 001.
//  5 ew_walk edge coincident with ack of 010 -> pending[1] remains 1 after ack.
//  6 Assert reset during BUSY -> grant, grant_valid, pending cleared within same cycle (async).

Source files
------------

// File: rtl/traffic_request_arbiter_if.sv
// Purpose: bundles the push-button request lines, the controller handshake
//          and the arbiter status outputs into one port for
//          traffic_request_arbiter.
// Signals:
//   not_ns_walk_request         button, active-low, asynchronous
//   not_ew_walk_request         button, active-low, asynchronous
//   not_southbound_left_request button, active-low, asynchronous
//   slot_ready                  controller at a phase boundary
//   grant_ack                   controller accepts the offered grant (pulse)
//   service_done                controller finished the granted service (pulse)
//   grant[2:0]                  one-hot {left, ew_walk, ns_walk}
//   grant_valid                 grant offered / being serviced
//   pending[2:0]                latched requests {left, ew_walk, ns_walk}
//   walk_request_waiting        |pending
//   timeout_err                 1-cycle pulse when an offer times out
// The master modport is the board/controller side; the slave modport is the arbiter.
interface traffic_request_arbiter_if;
  logic       not_ns_walk_request;
  logic       not_ew_walk_request;
  logic       not_southbound_left_request;
  logic       slot_ready;
  logic       grant_ack;
  logic       service_done;
  logic [2:0] grant;
  logic       grant_valid;
  logic [2:0] pending;
  logic       walk_request_waiting;
  logic       timeout_err;

  modport master (
    output not_ns_walk_request, not_ew_walk_request, not_southbound_left_request,
    output slot_ready, grant_ack, service_done,
    input  grant, grant_valid, pending, walk_request_waiting, timeout_err
  );

  modport slave (
    input  not_ns_walk_request, not_ew_walk_request, not_southbound_left_request,
    input  slot_ready, grant_ack, service_done,
    output grant, grant_valid, pending, walk_request_waiting, timeout_err
  );
endinterface

// File: rtl/traffic_request_arbiter.sv
// Purpose: synchronizes three push-button requests, latches them as pending
//          and hands them one at a time to the traffic controller in
//          round-robin order (ns_walk -> ew_walk -> left -> ns_walk ...).
// Ports:
//   clk_27  system clock, rising edge
//   reset   asynchronous, active-high
//   bus     traffic_request_arbiter_if.slave (buttons, handshake, status)
// Parameters:
//   SYNC_STAGES  flops per button synchronizer (>=2)
//   ACK_TIMEOUT  cycles an offer may wait for grant_ack before withdrawal
//   TO_W         timeout counter width; must hold ACK_TIMEOUT
module traffic_request_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                      clk_27,
  input  logic                      reset,
  traffic_request_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // Button bit order matches grant/pending: {left, ew_walk, ns_walk}.
  logic [2:0] btn_n;
  assign btn_n = {bus.not_southbound_left_request,
                  bus.not_ew_walk_request,
                  bus.not_ns_walk_request};

  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] prev_q;
  logic [2:0] fall;

  // NOTE: synchronizer flops reset to 1 (button released) so leaving reset
  // never looks like a press; they are real flops, not a memory, so they can
  // take a reset value.
  always_ff @(posedge clk_27 or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 3'b111;
      prev_q <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a shift chain.
      sync_q[0] <= btn_n;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Press = synchronized line going 1 -> 0; a held button yields one pulse.
  assign fall = prev_q & ~sync_q[SYNC_STAGES-1];

  state_t         state_q, state_d;
  logic [2:0]     pending_q, pending_d;
  logic [2:0]     grant_q, grant_d;
  logic           grant_valid_q, grant_valid_d;
  logic           timeout_err_q, timeout_err_d;
  logic [1:0]     rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]     clear_mask;
  logic [1:0]     rr_after_winner;

  // First set request found scanning upward from ptr, wrapping mod 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = '0;
    for (int k = 0; k < 3; k++) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (pick == '0 && req[idx]) pick[idx] = 1'b1;
    end
    return pick;
  endfunction

  // Pointer moves just past the winner so it goes to the back of the line.
  always_comb begin
    rr_after_winner = 2'd0;
    if (grant_q[0])      rr_after_winner = 2'd1;
    else if (grant_q[1]) rr_after_winner = 2'd2;
  end

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    timeout_err_d = 1'b0;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    clear_mask    = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.slot_ready && (|pending_q)) begin
          grant_d       = rr_pick(pending_q, rr_ptr_q);
          grant_valid_d = 1'b1;
          cnt_d         = '0;
          state_d       = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (bus.grant_ack) begin
          // An ack arriving on the timeout cycle still wins.
          clear_mask = grant_q;
          cnt_d      = '0;
          state_d    = ST_BUSY;
        end else if (cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = rr_after_winner;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (bus.service_done) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = rr_after_winner;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Set after clear: a fresh press on the winner in the ack cycle survives.
    pending_d = (pending_q & ~clear_mask) | fall;
  end

  always_ff @(posedge clk_27 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= 2'd0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      timeout_err_q <= timeout_err_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.grant                = grant_q;
  assign bus.grant_valid          = grant_valid_q;
  assign bus.pending              = pending_q;
  assign bus.walk_request_waiting = |pending_q;
  assign bus.timeout_err          = timeout_err_q;

endmodule

// File: tb/tb_traffic_request_arbiter.sv
module tb_traffic_request_arbiter;
  logic clk_27 = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  traffic_request_arbiter_if bus ();

  traffic_request_arbiter #(
    .SYNC_STAGES(2),
    .ACK_TIMEOUT(255),
    .TO_W(8)
  ) dut (
    .clk_27(clk_27),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_27 = ~clk_27;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_27);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full slot: offer, ack, done; checks the offered grant.
  task automatic serve(input string tag, input logic [2:0] exp_grant);
    bus.slot_ready = 1'b1;
    tick();
    bus.slot_ready = 1'b0;
    check({tag, "_grant"}, 32'(bus.grant), 32'(exp_grant));
    check({tag, "_gv"}, 32'(bus.grant_valid), 32'd1);
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    bus.service_done = 1'b1;
    tick();
    bus.service_done = 1'b0;
    check({tag, "_done_gv"}, 32'(bus.grant_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.not_ns_walk_request         = 1'b1;
    bus.not_ew_walk_request         = 1'b1;
    bus.not_southbound_left_request = 1'b1;
    bus.slot_ready   = 1'b0;
    bus.grant_ack    = 1'b0;
    bus.service_done = 1'b0;

    // 1: reset holds everything at zero even while buttons toggle
    repeat (2) tick();
    bus.not_ns_walk_request         = 1'b0;
    bus.not_ew_walk_request         = 1'b0;
    bus.not_southbound_left_request = 1'b0;
    repeat (3) tick();
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_gv", 32'(bus.grant_valid), 32'd0);
    check("rst_terr", 32'(bus.timeout_err), 32'd0);
    check("rst_wrw", 32'(bus.walk_request_waiting), 32'd0);
    bus.not_ns_walk_request         = 1'b1;
    bus.not_ew_walk_request         = 1'b1;
    bus.not_southbound_left_request = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("post_rst_pending", 32'(bus.pending), 32'd0);

    // 2: single ns_walk press, full handshake
    bus.not_ns_walk_request = 1'b0;
    repeat (2) tick();
    check("ns_pending_early", 32'(bus.pending), 32'd0);
    tick();
    check("ns_pending", 32'(bus.pending), 32'b001);
    check("ns_wrw", 32'(bus.walk_request_waiting), 32'd1);
    repeat (7) tick();
    bus.not_ns_walk_request = 1'b1;
    repeat (3) tick();
    check("ns_held_once", 32'(bus.pending), 32'b001);
    bus.grant_ack = 1'b1;                 // ack in IDLE is ignored
    tick();
    bus.grant_ack = 1'b0;
    check("idle_ack_pending", 32'(bus.pending), 32'b001);
    check("idle_ack_gv", 32'(bus.grant_valid), 32'd0);
    bus.slot_ready = 1'b1;
    tick();
    bus.slot_ready = 1'b0;
    check("ns_grant", 32'(bus.grant), 32'b001);
    check("ns_gv", 32'(bus.grant_valid), 32'd1);
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    check("ns_ack_pending", 32'(bus.pending), 32'b000);
    check("ns_ack_wrw", 32'(bus.walk_request_waiting), 32'd0);
    repeat (3) tick();
    check("ns_busy_gv", 32'(bus.grant_valid), 32'd1);
    check("ns_busy_grant", 32'(bus.grant), 32'b001);
    bus.service_done = 1'b1;
    tick();
    bus.service_done = 1'b0;
    check("ns_done_gv", 32'(bus.grant_valid), 32'd0);
    check("ns_done_grant", 32'(bus.grant), 32'd0);

    // 3: all three pending from rr_ptr=0 -> 001, 010, 100
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.not_ns_walk_request         = 1'b0;
    bus.not_ew_walk_request         = 1'b0;
    bus.not_southbound_left_request = 1'b0;
    repeat (3) tick();
    check("all_pending", 32'(bus.pending), 32'b111);
    bus.not_ns_walk_request         = 1'b1;
    bus.not_ew_walk_request         = 1'b1;
    bus.not_southbound_left_request = 1'b1;
    repeat (3) tick();
    serve("rr0", 3'b001);
    check("rr0_pending", 32'(bus.pending), 32'b110);
    serve("rr1", 3'b010);
    check("rr1_pending", 32'(bus.pending), 32'b100);
    serve("rr2", 3'b100);
    check("rr2_pending", 32'(bus.pending), 32'b000);

    // 4: ew offer times out; ns and left arrive meanwhile; rr_ptr -> 2
    bus.not_ew_walk_request = 1'b0;
    repeat (3) tick();
    bus.not_ew_walk_request = 1'b1;
    repeat (3) tick();
    check("to_pending_pre", 32'(bus.pending), 32'b010);
    bus.slot_ready = 1'b1;
    tick();
    bus.slot_ready = 1'b0;
    check("to_grant", 32'(bus.grant), 32'b010);
    for (int i = 0; i < 254; i++) begin
      if (i == 0) begin
        bus.not_ns_walk_request         = 1'b0;
        bus.not_southbound_left_request = 1'b0;
      end
      if (i == 4) begin
        bus.not_ns_walk_request         = 1'b1;
        bus.not_southbound_left_request = 1'b1;
      end
      tick();
    end
    check("to_last_gv", 32'(bus.grant_valid), 32'd1);
    check("to_last_terr", 32'(bus.timeout_err), 32'd0);
    tick();
    check("to_gv", 32'(bus.grant_valid), 32'd0);
    check("to_grant_clr", 32'(bus.grant), 32'd0);
    check("to_terr", 32'(bus.timeout_err), 32'd1);
    check("to_pending", 32'(bus.pending), 32'b111);
    tick();
    check("to_terr_pulse", 32'(bus.timeout_err), 32'd0);
    serve("after_to", 3'b100);
    serve("after_to2", 3'b001);
    serve("after_to3", 3'b010);
    check("after_to_pending", 32'(bus.pending), 32'b000);

    // 5: ew edge coincident with ack of an ew grant (rr_ptr=2)
    bus.not_ew_walk_request = 1'b0;
    repeat (3) tick();
    bus.not_ew_walk_request = 1'b1;
    repeat (3) tick();
    bus.slot_ready = 1'b1;
    tick();
    bus.slot_ready = 1'b0;
    check("coin_grant", 32'(bus.grant), 32'b010);
    bus.not_ew_walk_request = 1'b0;
    repeat (2) tick();
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    bus.not_ew_walk_request = 1'b1;
    check("coin_pending", 32'(bus.pending), 32'b010);
    check("coin_gv", 32'(bus.grant_valid), 32'd1);
    repeat (2) tick();
    bus.service_done = 1'b1;
    tick();
    bus.service_done = 1'b0;
    check("coin_done_gv", 32'(bus.grant_valid), 32'd0);
    check("coin_kept", 32'(bus.pending), 32'b010);

    // 6: press during BUSY, then async reset mid-BUSY
    tick();
    bus.slot_ready = 1'b1;
    tick();
    bus.slot_ready = 1'b0;
    check("r6_grant", 32'(bus.grant), 32'b010);
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    bus.not_ns_walk_request = 1'b0;
    repeat (3) tick();
    check("busy_press_pending", 32'(bus.pending), 32'b001);
    check("busy_press_gv", 32'(bus.grant_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_gv", 32'(bus.grant_valid), 32'd0);
    check("async_grant", 32'(bus.grant), 32'd0);
    check("async_pending", 32'(bus.pending), 32'd0);
    bus.not_ns_walk_request = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("final_pending", 32'(bus.pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
